// File: rtl/fft_stage_param_if.sv
// fft_stage_param_if: start/scale control, sample and twiddle buses, results and status of one FFT stage
interface fft_stage_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int N_POINTS   = 32
);
  logic start, scale_en, busy, done, ovf;
  logic [N_POINTS*DATA_WIDTH-1:0] in_real, in_imag, out_real, out_imag;
  logic [N_POINTS/2*DATA_WIDTH-1:0] tw_real, tw_imag;
  modport master (
    output start, scale_en, in_real, in_imag, tw_real, tw_imag,
    input  busy, done, ovf, out_real, out_imag
  );
  modport slave (
    input  start, scale_en, in_real, in_imag, tw_real, tw_imag,
    output busy, done, ovf, out_real, out_imag
  );
endinterface

// File: rtl/fft_stage_param.sv
// fft_stage_param: radix-2 DIT stage, NUM_BF two-stage pipelined butterflies time-multiplexed over N/(2*NUM_BF) passes
module fft_stage_param #(
  parameter int DATA_WIDTH = 8,
  parameter int FRACTION   = 4,
  parameter int N_POINTS   = 32,
  parameter int STAGE      = 3,
  parameter int NUM_BF     = 4
) (
  input logic clk,
  input logic reset,
  fft_stage_param_if.slave bus_if
);
  localparam int DW    = DATA_WIDTH;
  localparam int SPAN  = 2 ** (STAGE - 1);
  localparam int NPASS = N_POINTS / (2 * NUM_BF);
  localparam int PW    = NPASS > 1 ? $clog2(NPASS) : 1;
  localparam int IW    = $clog2(N_POINTS);
  localparam int MW    = 2 * DW + 1;
  localparam int PRW   = DW + 2;
  localparam int SW    = DW + 3;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] p_q;
  logic accept, scale_q, v_q, done_q, ovf_q;
  logic signed [DW-1:0] ar_q [N_POINTS];
  logic signed [DW-1:0] ai_q [N_POINTS];
  logic signed [DW-1:0] wr_q [N_POINTS/2];
  logic signed [DW-1:0] wi_q [N_POINTS/2];
  logic signed [DW-1:0] or_q [N_POINTS];
  logic signed [DW-1:0] oi_q [N_POINTS];
  logic signed [PRW-1:0] pr_q [NUM_BF];
  logic signed [PRW-1:0] pi_q [NUM_BF];
  logic signed [PRW-1:0] a1r_q [NUM_BF];
  logic signed [PRW-1:0] a1i_q [NUM_BF];
  logic signed [PRW-1:0] pr_d [NUM_BF];
  logic signed [PRW-1:0] pi_d [NUM_BF];
  logic [IW-1:0] t_q [NUM_BF];
  logic [IW-1:0] b_q [NUM_BF];
  logic [IW-1:0] t_d [NUM_BF];
  logic [IW-1:0] b_d [NUM_BF];
  logic [DW:0] xr_d [NUM_BF];
  logic [DW:0] xi_d [NUM_BF];
  logic [DW:0] yr_d [NUM_BF];
  logic [DW:0] yi_d [NUM_BF];
  logic [NUM_BF-1:0] ovf_d;
  // MSB of the result flags a clipped value
  function automatic logic [DW:0] sat(input logic signed [SW-1:0] s);
    return (&s[SW-1:DW-1] | ~|s[SW-1:DW-1]) ? {1'b0, s[DW-1:0]}
                                            : {1'b1, s[SW-1], {(DW-1){~s[SW-1]}}};
  endfunction
  assign accept = state_q == IDLE && bus_if.start;
  always_comb begin
    state_d = (state_q == IDLE) ? (bus_if.start ? RUN : IDLE)
            : (state_q == RUN)  ? (p_q == PW'(NPASS - 1) ? DRAIN : RUN)
            : IDLE;
  end
  for (genvar u = 0; u < NUM_BF; u++) begin : g_bf
    logic [IW-1:0] j, m;
    logic [IW-2:0] k;
    logic signed [MW-1:0] mr, mi;
    logic signed [SW-1:0] sxr, sxi, syr, syi;
    assign j = IW'(p_q) * IW'(NUM_BF) + IW'(u);
    assign m = j & IW'(SPAN - 1);
    assign t_d[u] = ((j >> (STAGE - 1)) << STAGE) | m;
    assign b_d[u] = t_d[u] + IW'(SPAN);
    assign k = (IW-1)'(m << (IW - STAGE));
    assign mr = MW'(wr_q[k]) * MW'(ar_q[b_d[u]]) - MW'(wi_q[k]) * MW'(ai_q[b_d[u]]);
    assign mi = MW'(wr_q[k]) * MW'(ai_q[b_d[u]]) + MW'(wi_q[k]) * MW'(ar_q[b_d[u]]);
    assign pr_d[u] = PRW'(mr >>> FRACTION);
    assign pi_d[u] = PRW'(mi >>> FRACTION);
    assign sxr = (SW'(a1r_q[u]) + SW'(pr_q[u])) >>> scale_q;
    assign sxi = (SW'(a1i_q[u]) + SW'(pi_q[u])) >>> scale_q;
    assign syr = (SW'(a1r_q[u]) - SW'(pr_q[u])) >>> scale_q;
    assign syi = (SW'(a1i_q[u]) - SW'(pi_q[u])) >>> scale_q;
    assign xr_d[u] = sat(sxr);
    assign xi_d[u] = sat(sxi);
    assign yr_d[u] = sat(syr);
    assign yi_d[u] = sat(syi);
    assign ovf_d[u] = xr_d[u][DW] | xi_d[u][DW] | yr_d[u][DW] | yi_d[u][DW];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      p_q     <= '0;
      v_q     <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < N_POINTS; i++) begin
        or_q[i] <= '0;
        oi_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      p_q     <= (state_q == RUN && state_d == RUN) ? p_q + PW'(1) : '0;
      v_q     <= state_q == RUN;
      done_q  <= state_q == DRAIN;
      ovf_q   <= accept ? 1'b0 : ovf_q | (v_q & |ovf_d);
      if (v_q) begin
        for (int i = 0; i < NUM_BF; i++) begin
          or_q[t_q[i]] <= xr_d[i][DW-1:0];
          oi_q[t_q[i]] <= xi_d[i][DW-1:0];
          or_q[b_q[i]] <= yr_d[i][DW-1:0];
          oi_q[b_q[i]] <= yi_d[i][DW-1:0];
        end
      end
    end
  end
  // operand capture and butterfly stage 1 need no reset: nothing is written out unless v_q
  always_ff @(posedge clk) begin
    if (accept) begin
      scale_q <= bus_if.scale_en;
      for (int i = 0; i < N_POINTS; i++) begin
        ar_q[i] <= bus_if.in_real[i*DW +: DW];
        ai_q[i] <= bus_if.in_imag[i*DW +: DW];
      end
      for (int i = 0; i < N_POINTS / 2; i++) begin
        wr_q[i] <= bus_if.tw_real[i*DW +: DW];
        wi_q[i] <= bus_if.tw_imag[i*DW +: DW];
      end
    end
    for (int i = 0; i < NUM_BF; i++) begin
      pr_q[i]  <= pr_d[i];
      pi_q[i]  <= pi_d[i];
      a1r_q[i] <= PRW'(ar_q[t_d[i]]);
      a1i_q[i] <= PRW'(ai_q[t_d[i]]);
      t_q[i]   <= t_d[i];
      b_q[i]   <= b_d[i];
    end
  end
  assign bus_if.busy = state_q != IDLE;
  assign bus_if.done = done_q;
  assign bus_if.ovf  = ovf_q;
  for (genvar i = 0; i < N_POINTS; i++) begin : g_out
    assign bus_if.out_real[i*DW +: DW] = or_q[i];
    assign bus_if.out_imag[i*DW +: DW] = oi_q[i];
  end
endmodule

// File: tb/tb_fft_stage_param.sv
// tb_fft_stage_param: three stage configurations share one stimulus; a latency/arithmetic model predicts every cycle
module tb_fft_stage_param;
  localparam int ST[3]    = '{3, 1, 5};
  localparam int NB[3]    = '{4, 16, 16};
  localparam int NPASS[3] = '{4, 1, 1};
  typedef struct packed {
    logic         ovf;
    logic [255:0] r;
    logic [255:0] i;
  } res_t;
  logic clk = 1'b0;
  logic reset, start, scale, armed;
  logic [255:0] in_real_v, in_imag_v;
  logic [127:0] tw_real_v, tw_imag_v;
  logic [255:0] o_r[3];
  logic [255:0] o_i[3];
  logic done_v[3], busy_v[3], ovf_v[3];
  logic m_busy[3], m_done[3];
  int   m_cnt[3];
  res_t m_pend[3], m_exp[3];
  int checks = 0, errors = 0, done_cnt = 0;
  always #5 clk = ~clk;
  for (genvar d = 0; d < 3; d++) begin : g_d
    fft_stage_param_if #(.DATA_WIDTH(8), .N_POINTS(32)) bus ();
    assign bus.start    = start;
    assign bus.scale_en = scale;
    assign bus.in_real  = in_real_v;
    assign bus.in_imag  = in_imag_v;
    assign bus.tw_real  = tw_real_v;
    assign bus.tw_imag  = tw_imag_v;
    assign o_r[d]    = bus.out_real;
    assign o_i[d]    = bus.out_imag;
    assign done_v[d] = bus.done;
    assign busy_v[d] = bus.busy;
    assign ovf_v[d]  = bus.ovf;
    fft_stage_param #(.DATA_WIDTH(8), .FRACTION(4), .N_POINTS(32), .STAGE(ST[d]), .NUM_BF(NB[d])) dut (
      .clk(clk), .reset(reset), .bus_if(bus)
    );
  end
  function automatic int s8(input logic [7:0] x);
    return int'($signed(x));
  endfunction
  function automatic int wrap10(input int x);
    int v;
    v = x & 1023;
    return v >= 512 ? v - 1024 : v;
  endfunction
  function automatic int clip(input int x);
    return x > 127 ? 127 : x < -128 ? -128 : x;
  endfunction
  // whole-transform result of one stage, computed pair by pair from the butterfly definition
  function automatic res_t model(input int stage, input logic sc, input logic [255:0] ir, ii,
                                 input logic [127:0] wr, wi);
    res_t res;
    int span, t, b, k, ar, ai, br, bi, w_r, w_i, pr, pim;
    int v[4];
    res = '0;
    span = 1 << (stage - 1);
    for (int g = 0; g < 16 / span; g++)
      for (int m = 0; m < span; m++) begin
        t = g * 2 * span + m;
        b = t + span;
        k = m * (16 / span);
        ar = s8(ir[t*8 +: 8]); ai = s8(ii[t*8 +: 8]);
        br = s8(ir[b*8 +: 8]); bi = s8(ii[b*8 +: 8]);
        w_r = s8(wr[k*8 +: 8]); w_i = s8(wi[k*8 +: 8]);
        pr  = wrap10((w_r * br - w_i * bi) >>> 4);
        pim = wrap10((w_r * bi + w_i * br) >>> 4);
        v[0] = (ar + pr) >>> sc; v[1] = (ai + pim) >>> sc;
        v[2] = (ar - pr) >>> sc; v[3] = (ai - pim) >>> sc;
        for (int q = 0; q < 4; q++) if (clip(v[q]) != v[q]) res.ovf = 1'b1;
        res.r[t*8 +: 8] = 8'(clip(v[0])); res.i[t*8 +: 8] = 8'(clip(v[1]));
        res.r[b*8 +: 8] = 8'(clip(v[2])); res.i[b*8 +: 8] = 8'(clip(v[3]));
      end
    return res;
  endfunction
  task automatic check(input string nm, input int d, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d act=%h exp=%h", nm, d, act, exp);
    end
  endtask
  function automatic logic [7:0] byte_of(input logic [255:0] v, input int i);
    return v[i*8 +: 8];
  endfunction
  // a run accepted at one edge completes at the (P+1)th following edge
  always @(posedge clk)
    for (int d = 0; d < 3; d++) begin
      if (reset) begin
        m_busy[d] <= 1'b0; m_done[d] <= 1'b0; m_cnt[d] <= 0; m_exp[d] <= '0;
      end else if (m_busy[d]) begin
        m_cnt[d]  <= m_cnt[d] + 1;
        m_done[d] <= m_cnt[d] == NPASS[d] + 1;
        if (m_cnt[d] == NPASS[d] + 1) begin
          m_busy[d] <= 1'b0;
          m_exp[d]  <= m_pend[d];
        end
      end else begin
        m_done[d] <= 1'b0;
        if (start) begin
          m_busy[d] <= 1'b1;
          m_cnt[d]  <= 1;
          m_pend[d] <= model(ST[d], scale, in_real_v, in_imag_v, tw_real_v, tw_imag_v);
        end
      end
    end
  always @(negedge clk) begin
    if (done_v[0]) done_cnt++;
    if (armed)
      for (int d = 0; d < 3; d++) begin
        check("done", d, 256'(done_v[d]), 256'(m_done[d]));
        check("busy", d, 256'(busy_v[d]), 256'(m_busy[d]));
        if (!m_busy[d]) begin
          check("ovf", d, 256'(ovf_v[d]), 256'(m_exp[d].ovf));
          check("out_real", d, o_r[d], m_exp[d].r);
          check("out_imag", d, o_i[d], m_exp[d].i);
        end
      end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic base();
    in_real_v = '0; in_imag_v = '0; tw_imag_v = '0;
    for (int k = 0; k < 16; k++) tw_real_v[k*8 +: 8] = 8'h10;
  endtask
  task automatic pulse(input logic sc);
    start = 1'b1; scale = sc;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_done(input int d, output int lat);
    lat = 0;
    while (!done_v[d] && lat < 40) begin
      tick();
      lat++;
    end
    if (!done_v[d]) begin
      checks++; errors++;
      $display("FAIL wait_done dut%0d act=timeout exp=done", d);
    end
  endtask
  int lat, n0;
  initial begin
    reset = 1'b1; start = 1'b0; scale = 1'b0; armed = 1'b0;
    base();
    tick();
    armed = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_busy", 0, 256'(busy_v[0]), 256'(0));
    check("rst_done", 0, 256'(done_v[0]), 256'(0));
    check("rst_ovf", 0, 256'(ovf_v[0]), 256'(0));
    check("rst_out", 0, o_r[0], 256'(0));
    // identity
    in_real_v[0*8 +: 8] = 8'h10; in_real_v[4*8 +: 8] = 8'h08;
    pulse(1'b0); wait_done(0, lat);
    check("id_lat", 0, 256'(lat), 256'(5));
    check("id_out0r", 0, 256'(byte_of(o_r[0], 0)), 256'(8'h18));
    check("id_out0i", 0, 256'(byte_of(o_i[0], 0)), 256'(8'h00));
    check("id_out4r", 0, 256'(byte_of(o_r[0], 4)), 256'(8'h08));
    check("id_ovf", 0, 256'(ovf_v[0]), 256'(0));
    // scaling, started in the done cycle
    pulse(1'b1); wait_done(0, lat);
    check("sc_lat", 0, 256'(lat), 256'(5));
    check("sc_out0r", 0, 256'(byte_of(o_r[0], 0)), 256'(8'h0C));
    check("sc_out4r", 0, 256'(byte_of(o_r[0], 4)), 256'(8'h04));
    // saturation, then a benign run clears ovf
    in_real_v[0*8 +: 8] = 8'h70; in_real_v[4*8 +: 8] = 8'h70;
    tick();
    pulse(1'b0); wait_done(0, lat);
    check("sat_out0r", 0, 256'(byte_of(o_r[0], 0)), 256'(8'h7F));
    check("sat_out4r", 0, 256'(byte_of(o_r[0], 4)), 256'(8'h00));
    check("sat_ovf", 0, 256'(ovf_v[0]), 256'(1));
    in_real_v[0*8 +: 8] = 8'h10; in_real_v[4*8 +: 8] = 8'h08;
    tick();
    pulse(1'b0); wait_done(0, lat);
    check("clr_ovf", 0, 256'(ovf_v[0]), 256'(0));
    // complex twiddle -j on entry 8, pair (2,6)
    base();
    tw_real_v[8*8 +: 8] = 8'h00; tw_imag_v[8*8 +: 8] = 8'hF0;
    in_real_v[2*8 +: 8] = 8'h10; in_real_v[6*8 +: 8] = 8'h10;
    tick();
    pulse(1'b0); wait_done(0, lat);
    check("cx_out2r", 0, 256'(byte_of(o_r[0], 2)), 256'(8'h10));
    check("cx_out2i", 0, 256'(byte_of(o_i[0], 2)), 256'(8'hF0));
    check("cx_out6r", 0, 256'(byte_of(o_r[0], 6)), 256'(8'h10));
    check("cx_out6i", 0, 256'(byte_of(o_i[0], 6)), 256'(8'h10));
    // start held through edges 1..4 is ignored, then back-to-back from the done cycle
    base();
    in_real_v[0*8 +: 8] = 8'h10; in_real_v[4*8 +: 8] = 8'h08;
    tick();
    n0 = done_cnt;
    pulse(1'b0);
    start = 1'b1;
    repeat (4) tick();
    start = 1'b0;
    wait_done(0, lat);
    check("hs_lat", 0, 256'(lat + 4), 256'(5));
    pulse(1'b0); wait_done(0, lat);
    check("b2b_lat", 0, 256'(lat), 256'(5));
    repeat (8) tick();
    check("hs_dones", 0, 256'(done_cnt - n0), 256'(2));
    // reset sampled at edge 2 of a run
    pulse(1'b0); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mr_busy", 0, 256'(busy_v[0]), 256'(0));
    check("mr_out", 0, o_r[0], 256'(0));
    n0 = done_cnt;
    repeat (8) tick();
    check("mr_nodone", 0, 256'(done_cnt - n0), 256'(0));
    pulse(1'b0); wait_done(0, lat);
    check("mr_lat", 0, 256'(lat), 256'(5));
    // NUM_BF=16 units: STAGE=1 and STAGE=5 mappings, two-cycle latency
    in_real_v[1*8 +: 8] = 8'h08; in_real_v[16*8 +: 8] = 8'h08; in_real_v[4*8 +: 8] = 8'h00;
    tick();
    pulse(1'b0); wait_done(1, lat);
    check("nb_lat", 1, 256'(lat), 256'(2));
    check("nb_c_done", 2, 256'(done_v[2]), 256'(1));
    check("s1_out0r", 1, 256'(byte_of(o_r[1], 0)), 256'(8'h18));
    check("s1_out1r", 1, 256'(byte_of(o_r[1], 1)), 256'(8'h08));
    check("s5_out0r", 2, 256'(byte_of(o_r[2], 0)), 256'(8'h18));
    check("s5_out16r", 2, 256'(byte_of(o_r[2], 16)), 256'(8'h08));
    repeat (8) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fft_stage_param.md
Name: fft_stage_param

Overview:
- Generic radix-2 decimation-in-time FFT stage. It replaces the fixed per-stage modules with one block parametrised by point count, stage index and number of physical butterfly units.
- Captures all N complex samples on start and time-multiplexes NUM_BF pipelined butterflies over N/(2*NUM_BF) passes.
- Writes registered results and pulses done. Adds optional per-stage scaling, saturation and a sticky overflow flag.
- Instances are chained stage to stage: the done of one stage drives the start of the next.

Parameters:
- DATA_WIDTH, 8, signed two's-complement width of each real and imaginary component.
- FRACTION, 4, fractional bits in the Q format, shared by data and twiddles.
- N_POINTS, 32, FFT size. Power of two, at least 4.
- STAGE, 3, stage index from 1 to log2(N_POINTS). Butterfly span SPAN = 2^(STAGE-1).
- NUM_BF, 4, physical butterfly units. Must divide N_POINTS/2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle request. Sampled only in IDLE.
- scale_en  in  1  when 1, each butterfly output is arithmetically shifted right by 1 before saturation. Captured with start.
- in_real  in  N_POINTS*DATA_WIDTH  flattened inputs. Sample i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_imag  in  N_POINTS*DATA_WIDTH  same layout as in_real.
- tw_real  in  (N_POINTS/2)*DATA_WIDTH  twiddle table. Entry k = Re(W_N^k).
- tw_imag  in  (N_POINTS/2)*DATA_WIDTH  twiddle table. Entry k = Im(W_N^k).
- out_real  out  N_POINTS*DATA_WIDTH  registered results, same layout as in_real.
- out_imag  out  N_POINTS*DATA_WIDTH  registered results, same layout as in_imag.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse: every output holds this run's result.
- ovf  out  1  sticky saturation flag for the current run. Cleared when start is accepted.

Behaviour:
- Reset: state IDLE, all outputs 0, pass counter 0. A reset mid-run aborts immediately, done is not issued, and outputs return to 0.
- States and transitions:
  - IDLE -> RUN on start. All inputs and scale_en are captured into internal registers at that edge, so inputs need only be valid in the start cycle.
  - RUN: pass counter p runs 0 to P-1, where P = N_POINTS/(2*NUM_BF). RUN -> DRAIN after p = P-1 is issued.
  - DRAIN: one cycle, then -> IDLE.
- start while busy is ignored, with no effect on the counter or captured data.
- Butterfly index mapping for butterfly j in pass p, with j = p*NUM_BF + u for unit u:
  - g = j/SPAN, m = j%SPAN.
  - top index t = g*2*SPAN + m; bottom index b = t + SPAN.
  - twiddle index k = m*(N_POINTS/(2*SPAN)).
- Butterfly pipeline, 2 stages:
  - Stage 1 registers P = W*B: real = Wr*Br - Wi*Bi, imag = Wr*Bi + Wi*Br. Computed at 2*DATA_WIDTH+1 bits, then arithmetic right shift by FRACTION (truncation), kept at DATA_WIDTH+2 bits.
  - Stage 1 also registers A, sign-extended.
  - Stage 2 computes X = A + P and Y = A - P, optionally >>>1 if scale_en, then saturates to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Stage 2 writes out[t] = X and out[b] = Y. Any saturation event sets ovf.
- Timing, with the start edge as edge 0:
  - Pass p operands are selected at edge p+1 and written at edge p+2.
  - The final write occurs at edge P+1; done = 1 and busy = 0 from that edge for one cycle.
  - Latency is P+1 cycles. For N=32, NUM_BF=4 this is 5; for NUM_BF=16 it is 2.
- Output update: outputs not yet rewritten in the current run keep their previous values. Only at done is the whole bus guaranteed coherent.
- Back-to-back runs: start may be asserted in the cycle done is high. The block is IDLE in that cycle, so the next run begins without a gap.

Test Plan (DATA_WIDTH=8, FRACTION=4, so 1.0 = 0x10):
- Identity, N=32, STAGE=3, all twiddles = (0x10, 0): in0 = (0x10, 0), in4 = (0x08, 0), start -> exactly 5 cycles later done=1, out0 = (0x18, 0), out4 = (0x08, 0), ovf=0.
- Scaling: same stimulus with scale_en=1 -> out0 = (0x0C, 0), out4 = (0x04, 0).
- Saturation: in0 = in4 = (0x70, 0), W = 1 -> out0 = (0x7F, 0), out4 = (0x00, 0), ovf=1. The next start with benign data clears ovf.
- Complex twiddle:
  - Setup: tw entry 8 = (0, 0xF0), i.e. -j; in2 = (0x10, 0); in6 = (0x10, 0).
  - Required: out2 = (0x10, 0xF0), out6 = (0x10, 0x10).
  - This also checks the index mapping for STAGE=3, since sample pair (2, 6) uses twiddle entry 8.
- Handshake: start again at edges 1 to 4 of a run -> ignored, exactly one done. start in the done cycle -> second done exactly 5 cycles later.
- Reset mid-run: reset at edge 2 -> all outputs 0, busy=0, no done, and a later start completes normally. Repeat with NUM_BF=16 to check 2-cycle latency and the mapping for STAGE=1 and STAGE=5.
